fg_config_loader: RTL and testbench

FG_CONFIG_LOADER -- requirements
Module: fg_config_loader

---
 rtl/fg_pkg.sv | 54 +++++
 rtl/fg_config_loader_sync.sv | 24 ++
 rtl/fg_config_loader.sv | 216 +++++++++++++++++++++
 tb/tb_fg_config_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_pkg.sv
// Shared opcodes, FSM states and frame decode for the function-generator config loader.
// Imported by the loader top and its SPI synchronizers.
package fg_pkg;

  localparam logic [4:0] OP_WRITE = 5'b10100;
  localparam logic [4:0] OP_RUN   = 5'b11000;
  localparam logic [4:0] OP_STOP  = 5'b11001;

  localparam logic [2:0] NOWRITE_ADDR = 3'd7;

  localparam int BCNT_W = 5;
  localparam logic [BCNT_W-1:0] FRAME_LEN = 5'd16;

  typedef enum logic [2:0] {
    IDLE,
    PAUSE,
    SETUP,
    STROBE,
    HOLD,
    RESUME
  } fg_state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_WRITE,
    CMD_RUN,
    CMD_STOP
  } fg_cmd_t;

  typedef struct packed {
    fg_cmd_t    cmd;
    logic [2:0] addr;
    logic [7:0] data;
  } fg_frame_t;

  // Unknown opcodes and writes to the parking address decode as CMD_NONE.
  function automatic fg_frame_t decode_frame(input logic [15:0] bits);
    fg_frame_t f;
    f.cmd  = CMD_NONE;
    f.addr = bits[10:8];
    f.data = bits[7:0];
    case (bits[15:11])
      OP_WRITE: begin
        if (bits[10:8] != NOWRITE_ADDR)
          f.cmd = CMD_WRITE;
      end
      OP_RUN:   f.cmd = CMD_RUN;
      OP_STOP:  f.cmd = CMD_STOP;
      default:  f.cmd = CMD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fg_config_loader_sync.sv
// Multi-flop synchronizer for one asynchronous SPI input.
// Resets to the line's idle level so no false edge appears after reset.
module FG_Synchronizer #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_sync <= {STAGES{RST_VAL}};
    else
      r_sync <= (r_sync << 1) | STAGES'(d_i);
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/fg_config_loader.sv
// SPI-to-parallel configuration loader for the function generator.
// Writes pause a running generator around a setup/strobe/hold bus cycle.
module fg_config_loader
  import fg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic [7:0] data_o,
  output logic [2:0] addr_o,
  output logic       wr_n_o,
  output logic       en_n_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic w_sclk;
  logic w_cs_n;
  logic w_mosi;

  FG_Synchronizer #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_sclk (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (sclk_i),
    .q_o  (w_sclk)
  );

  FG_Synchronizer #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync_cs_n (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (cs_n_i),
    .q_o  (w_cs_n)
  );

  FG_Synchronizer #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_mosi (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (mosi_i),
    .q_o  (w_mosi)
  );

  logic              r_sclk_q;
  logic              r_cs_n_q;
  logic [15:0]       r_shift;
  logic [BCNT_W-1:0] r_bcnt;

  logic w_sclk_rise;
  logic w_cs_fall;
  logic w_cs_rise;

  assign w_sclk_rise = w_sclk & ~r_sclk_q;
  assign w_cs_fall   = ~w_cs_n & r_cs_n_q;
  assign w_cs_rise   = w_cs_n & ~r_cs_n_q;

  // Bit counter saturates so long frames can never wrap back to 16.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sclk_q <= 1'b0;
      r_cs_n_q <= 1'b1;
      r_shift  <= '0;
      r_bcnt   <= '0;
    end else begin
      r_sclk_q <= w_sclk;
      r_cs_n_q <= w_cs_n;
      if (w_cs_fall) begin
        r_bcnt <= '0;
      end else if (!w_cs_n && w_sclk_rise) begin
        r_shift <= {r_shift[14:0], w_mosi};
        if (r_bcnt != '1)
          r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  fg_frame_t w_frame;
  logic      w_len_ok;
  logic      w_accept;
  logic      w_reject;

  assign w_frame  = decode_frame(r_shift);
  assign w_len_ok = (r_bcnt == FRAME_LEN);
  assign w_accept = w_cs_rise && w_len_ok && !busy_o &&
                    (w_frame.cmd != CMD_NONE);
  assign w_reject = w_cs_rise && !w_accept;

  fg_state_t        r_state;
  logic [CNT_W-1:0] r_phase;
  logic [7:0]       r_data;
  logic [2:0]       r_addr;
  logic             r_wr_n;
  logic             r_en_n;
  logic             r_busy;
  logic             r_err;
  logic             r_run_was;
  logic [7:0]       r_pend_data;
  logic [2:0]       r_pend_addr;

  logic w_phase_done;
  assign w_phase_done = (r_phase == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_data      <= '0;
      r_addr      <= NOWRITE_ADDR;
      r_wr_n      <= 1'b1;
      r_en_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_run_was   <= 1'b0;
      r_pend_data <= '0;
      r_pend_addr <= '0;
    end else begin
      r_err <= w_reject;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (w_frame.cmd)
              CMD_WRITE: begin
                r_run_was   <= !r_en_n;
                r_busy      <= 1'b1;
                r_pend_data <= w_frame.data;
                r_pend_addr <= w_frame.addr;
                r_phase     <= PHASE_LOAD;
                if (!r_en_n) begin
                  r_en_n  <= 1'b1;
                  r_state <= PAUSE;
                end else begin
                  r_data  <= w_frame.data;
                  r_addr  <= w_frame.addr;
                  r_state <= SETUP;
                end
              end
              CMD_RUN:  r_en_n <= 1'b0;
              CMD_STOP: r_en_n <= 1'b1;
              default:  r_en_n <= r_en_n;
            endcase
          end
        end
        PAUSE: begin
          if (w_phase_done) begin
            r_data  <= r_pend_data;
            r_addr  <= r_pend_addr;
            r_phase <= PHASE_LOAD;
            r_state <= SETUP;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        SETUP: begin
          if (w_phase_done) begin
            r_wr_n  <= 1'b0;
            r_phase <= PHASE_LOAD;
            r_state <= STROBE;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        STROBE: begin
          if (w_phase_done) begin
            r_wr_n  <= 1'b1;
            r_phase <= PHASE_LOAD;
            r_state <= HOLD;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        HOLD: begin
          if (w_phase_done) begin
            r_en_n  <= !r_run_was;
            r_addr  <= NOWRITE_ADDR;
            r_phase <= PHASE_LOAD;
            r_state <= RESUME;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        RESUME: begin
          r_busy  <= 1'b0;
          r_phase <= PHASE_LOAD;
          r_state <= IDLE;
        end
        default: begin
          r_phase <= PHASE_LOAD;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign data_o = r_data;
  assign addr_o = r_addr;
  assign wr_n_o = r_wr_n;
  assign en_n_o = r_en_n;
  assign busy_o = r_busy;
  assign err_o  = r_err;

endmodule

// File: tb/tb_fg_config_loader.sv
// Scoreboard bench for fg_config_loader: random and directed SPI frames.
// A second, slow-phase instance exercises the overrun path.
module tb_fg_config_loader;

  localparam int H  = 4;
  localparam int HS = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;

  logic [7:0] data_o, data_s;
  logic [2:0] addr_o, addr_s;
  logic wr_n_o, en_n_o, busy_o, err_o;
  logic wr_n_s, en_n_s, busy_s, err_s;

  fg_config_loader #(.SYNC_STAGES(2), .HOLD_CYCLES(H)) u_dut (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n),
    .mosi_i(mosi), .data_o(data_o), .addr_o(addr_o),
    .wr_n_o(wr_n_o), .en_n_o(en_n_o), .busy_o(busy_o),
    .err_o(err_o)
  );

  fg_config_loader #(.SYNC_STAGES(2), .HOLD_CYCLES(HS)) u_slow (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n),
    .mosi_i(mosi), .data_o(data_s), .addr_o(addr_s),
    .wr_n_o(wr_n_s), .en_n_o(en_n_s), .busy_o(busy_s),
    .err_o(err_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         blen;
    logic       en_after;
  } wr_exp_t;

  wr_exp_t wr_q[$];
  logic    en_q[$];
  int      err_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit model_running = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outcome of one completed frame on an idle loader.
  task automatic model(input logic [15:0] f, input int nbits);
    wr_exp_t e;
    if (nbits != 16) begin
      err_q.push_back(1);
    end else begin
      case (f[15:11])
        5'b10100: begin
          if (f[10:8] == 3'd7) begin
            err_q.push_back(1);
          end else begin
            e.addr     = f[10:8];
            e.data     = f[7:0];
            e.blen     = model_running ? 4*H+1 : 3*H+1;
            e.en_after = !model_running;
            wr_q.push_back(e);
          end
        end
        5'b11000: begin
          if (!model_running) en_q.push_back(1'b0);
          model_running = 1'b1;
        end
        5'b11001: begin
          if (model_running) en_q.push_back(1'b1);
          model_running = 1'b0;
        end
        default: err_q.push_back(1);
      endcase
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    model_running = 1'b0;
    clks(4);
  endtask

  task automatic spi_frame(input logic [31:0] bits, input int nbits,
                           input int rst_at);
    @(negedge clk);
    cs_n = 1'b0;
    clks(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) pulse_rst();
      mosi = bits[nbits-1-i];
      clks(4);
      sclk = 1'b1;
      clks(4);
      sclk = 1'b0;
    end
    clks(4);
    cs_n = 1'b1;
    mosi = 1'b0;
  endtask

  task automatic send(input logic [15:0] f);
    spi_frame({16'h0, f}, 16, -1);
    model(f, 16);
  endtask

  task automatic wait_idle();
    int n = 0;
    clks(8);
    while (busy_o && n < 200) begin
      clks(1);
      n++;
    end
    if (busy_o) chk("idle_timeout", busy_o, 0);
    clks(3);
  endtask

  task automatic wait_idle_slow();
    int n = 0;
    clks(8);
    while (busy_s && n < 1000) begin
      clks(1);
      n++;
    end
    if (busy_s) chk("slow_idle_timeout", busy_s, 0);
  endtask

  // Monitor: compares observed DUT events against the scoreboard queues.
  logic       m_busy = 1'b0;
  logic       m_en   = 1'b1;
  logic       m_err  = 1'b0;
  int         m_blen = 0;
  int         m_wlen = 0;
  logic [2:0] m_addr = '0;
  logic [7:0] m_data = '0;
  wr_exp_t    m_e;

  always @(negedge clk) begin
    if (rst) begin
      wr_q.delete();
      en_q.delete();
      err_q.delete();
      m_busy = 1'b0;
      m_en   = 1'b1;
      m_err  = 1'b0;
      m_blen = 0;
      m_wlen = 0;
    end else begin
      if (!wr_n_o && !en_n_o) chk("wr_while_enabled", en_n_o, 1);
      if (!busy_o && !wr_n_o) chk("wr_outside_busy", busy_o, 1);
      if (busy_o) begin
        m_blen++;
        if (!wr_n_o) begin
          if (m_wlen == 0) begin
            m_addr = addr_o;
            m_data = data_o;
          end else if (addr_o !== m_addr || data_o !== m_data) begin
            chk("wr_bus_stable", {addr_o, data_o}, {m_addr, m_data});
          end
          m_wlen++;
        end
      end
      if (m_busy && !busy_o) begin
        chk("write_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          m_e = wr_q.pop_front();
          chk("wr_addr", m_addr, m_e.addr);
          chk("wr_data", m_data, m_e.data);
          chk("wr_len", m_wlen, H);
          chk("busy_len", m_blen, m_e.blen);
          chk("en_after_write", en_n_o, m_e.en_after);
          chk("addr_parked", addr_o, 3'd7);
        end
        m_blen = 0;
        m_wlen = 0;
      end
      if (!busy_o && !m_busy && en_n_o !== m_en) begin
        if (en_q.size() == 0) chk("unexpected_en_change", en_n_o, m_en);
        else chk("en_level", en_n_o, en_q.pop_front());
      end
      if (err_o && m_err) begin
        chk("err_width", 1, 0);
      end else if (err_o) begin
        chk("err_expected", err_q.size() != 0, 1);
        if (err_q.size() != 0) void'(err_q.pop_front());
      end
      m_busy = busy_o;
      m_en   = en_n_o;
      m_err  = err_o;
    end
  end

  int         s_wr = 0;
  int         s_err = 0;
  logic       s_wr_p = 1'b1;
  logic       s_err_p = 1'b0;
  logic [2:0] s_addr = '0;
  logic [7:0] s_data = '0;

  always @(negedge clk) begin
    if (!wr_n_s && s_wr_p) begin
      s_wr++;
      s_addr = addr_s;
      s_data = data_s;
    end
    if (err_s && !s_err_p) s_err++;
    s_wr_p  = wr_n_s;
    s_err_p = err_s;
  end

  initial begin
    int wr0, er0, k, n, tmo;
    logic [4:0]  op;
    logic [15:0] f;
    logic [31:0] r;

    clks(3);
    chk("rst_data", data_o, 8'h00);
    chk("rst_addr", addr_o, 3'd7);
    chk("rst_wr_n", wr_n_o, 1'b1);
    chk("rst_en_n", en_n_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    clks(4);

    // Overrun on the slow instance: second frame lands in its STROBE.
    wr0 = s_wr;
    er0 = s_err;
    send(16'hA25A);
    send(16'hA3C3);
    wait_idle_slow();
    chk("ovr_strobes", s_wr - wr0, 1);
    chk("ovr_errs", s_err - er0, 1);
    chk("ovr_addr", s_addr, 3'd2);
    chk("ovr_data", s_data, 8'h5A);
    wait_idle();

    send(16'hA532);
    wait_idle();
    send(16'hC000);
    wait_idle();
    send(16'hA105);
    wait_idle();

    spi_frame(32'h1234, 15, -1);
    model(16'h1234, 15);
    wait_idle();
    send(16'h0012);
    wait_idle();
    send(16'hA7FF);
    wait_idle();
    send(16'hC000);
    wait_idle();
    send(16'hC800);
    wait_idle();
    send(16'hC800);
    wait_idle();

    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 6);
      r = $urandom;
      case (k)
        0, 1: begin
          f = {5'b10100, 3'($urandom_range(0, 6)), r[7:0]};
          send(f);
        end
        2: send(16'hC000 | {8'h00, r[7:0]});
        3: send(16'hC800 | {5'h00, r[10:0]});
        4: begin
          op = 5'($urandom_range(0, 31));
          while (op == 5'b10100 || op == 5'b11000 || op == 5'b11001)
            op = 5'($urandom_range(0, 31));
          send({op, r[10:0]});
        end
        5: begin
          n = $urandom_range(1, 20);
          if (n == 16) n = 17;
          spi_frame(r, n, -1);
          model(r[15:0], n);
        end
        default: send({5'b10100, 3'd7, r[7:0]});
      endcase
      wait_idle();
    end

    // Reset while strobing from the running state.
    send(16'hC000);
    wait_idle();
    send(16'hA477);
    tmo = 0;
    while (wr_n_o && tmo < 100) begin
      clks(1);
      tmo++;
    end
    if (wr_n_o) chk("strobe_timeout", wr_n_o, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_strobe_wr_n", wr_n_o, 1'b1);
    chk("rst_strobe_en_n", en_n_o, 1'b1);
    chk("rst_strobe_busy", busy_o, 1'b0);
    chk("rst_strobe_data", data_o, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_running = 1'b0;
    clks(60);
    chk("no_strobe_after_rst", wr_n_o, 1'b1);

    // Reset in the middle of a frame: the tail must be rejected.
    spi_frame(32'hA311, 16, 8);
    err_q.push_back(1);
    wait_idle();
    send(16'hA69C);
    wait_idle();

    clks(20);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("en_q_drained", en_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
